// File: rtl/v14_pulse_gen_pkg.sv
// Shared constants and types for the v14 synthetic pulse source and its shaping filter.
// Keep PULSE_DECAY_SHIFT/PULSE_FRAC in step with the filter's M_14 coefficient.
package v14_parameters;

  localparam int unsigned PULSE_ADC_WIDTH   = 12;
  localparam int unsigned PULSE_BASELINE    = 100;
  localparam int unsigned PULSE_RISE_SHIFT  = 0;
  localparam int unsigned PULSE_DECAY_SHIFT = 4;
  localparam int unsigned PULSE_FRAC        = 4;
  localparam int unsigned PULSE_PERIOD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/v14_pulse_gen_timer.sv
// Free-running auto-trigger counter: strobes fire_o once every period_i cycles.
// A new period is only adopted at a wrap; period_i == 0 parks the counter at 0.
module v14_pulse_timer
  import v14_parameters::*;
#(
  parameter int unsigned PERIOD_W = PULSE_PERIOD_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                fire_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] eff_period;

  // period_q == 0 means "not yet latched": the live input is used until the first wrap.
  assign eff_period = (period_q == '0) ? period_i : period_q;
  assign fire_o     = (period_i != '0) && (cnt_q == eff_period - PERIOD_W'(1));

  always_comb begin
    cnt_d    = cnt_q + PERIOD_W'(1);
    period_d = period_q;
    if (period_i == '0) begin
      cnt_d    = '0;
      period_d = '0;
    end else if (fire_o) begin
      cnt_d    = '0;
      period_d = period_i;
    end else if (period_q == '0) begin
      period_d = period_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/v14_pulse_gen.sv
// Synthetic detector-pulse source: baseline plus piled-up exponential-decay pulses,
// one ADC-format sample per clock, triggered externally or by the auto timer.
module v14_pulse_gen
  import v14_parameters::*;
#(
  parameter int unsigned SIZE_ADC_DATA = PULSE_ADC_WIDTH,
  parameter int unsigned BASELINE      = PULSE_BASELINE,
  parameter int unsigned RISE_SHIFT    = PULSE_RISE_SHIFT,
  parameter int unsigned DECAY_SHIFT   = PULSE_DECAY_SHIFT,
  parameter int unsigned FRAC          = PULSE_FRAC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trig_valid,
  input  logic [SIZE_ADC_DATA-1:0] trig_amp,
  output logic                     trig_ready,
  input  logic [15:0]              auto_period,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     pulse_start,
  output logic                     busy
);

  localparam int unsigned ACC_W = SIZE_ADC_DATA + FRAC + 1;
  localparam int unsigned CNT_W = RISE_SHIFT + 1;
  localparam int unsigned OUT_W = SIZE_ADC_DATA + 2;

  localparam logic [ACC_W-1:0]         ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]         RISE_LEN = CNT_W'(1) << RISE_SHIFT;
  localparam logic [OUT_W-1:0]         OUT_MAX  = {2'b00, {SIZE_ADC_DATA{1'b1}}};
  localparam logic [SIZE_ADC_DATA-1:0] OUT_RST  = SIZE_ADC_DATA'(BASELINE);

  pulse_state_t state_q, state_d;

  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W-1:0]         step_q, step_d;
  logic [CNT_W-1:0]         rise_cnt_q, rise_cnt_d;
  logic [SIZE_ADC_DATA-1:0] out_q, out_d;
  logic                     pulse_start_q;
  logic                     busy_q;

  logic             auto_fire;
  logic             accept;
  logic [ACC_W-1:0] step_new;
  logic [ACC_W-1:0] decayed;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum_new, sat_new;
  logic [ACC_W-1:0] sum_rise, sat_rise;
  logic [OUT_W-1:0] out_sum;

  v14_pulse_timer #(
    .PERIOD_W (16)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .period_i (auto_period),
    .fire_o   (auto_fire)
  );

  // External and auto requests merge here, so a coincidence yields one pulse.
  assign trig_ready = (state_q != RISE);
  assign accept     = trig_ready && (trig_valid || auto_fire);

  assign step_new = (ACC_W'(trig_amp) << FRAC) >> RISE_SHIFT;
  assign decayed  = acc_q - (acc_q >> DECAY_SHIFT);
  assign base     = (state_q == IDLE) ? '0 : decayed;

  // Operands never exceed ACC_MAX, so the spare top bit of the sum flags overflow.
  assign sum_new  = base + step_new;
  assign sat_new  = sum_new[ACC_W-1] ? ACC_MAX : sum_new;
  assign sum_rise = acc_q + step_q;
  assign sat_rise = sum_rise[ACC_W-1] ? ACC_MAX : sum_rise;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    rise_cnt_d = rise_cnt_q;
    case (state_q)
      RISE: begin
        acc_d      = sat_rise;
        rise_cnt_d = rise_cnt_q - CNT_W'(1);
        if (rise_cnt_q == CNT_W'(1)) begin
          state_d = DECAY;
        end
      end
      default: begin
        if (accept) begin
          step_d     = step_new;
          rise_cnt_d = RISE_LEN;
          // A zero-length rise collapses into a single step on the accepting edge.
          if (RISE_SHIFT == 0) begin
            acc_d   = sat_new;
            state_d = DECAY;
          end else begin
            acc_d   = base;
            state_d = RISE;
          end
        end else if ((state_q == IDLE) || ((acc_q >> FRAC) == '0)) begin
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = decayed;
        end
      end
    endcase
  end

  assign out_sum = OUT_W'(acc_q >> FRAC) + OUT_W'(BASELINE);
  assign out_d   = (out_sum > OUT_MAX) ? OUT_MAX[SIZE_ADC_DATA-1:0]
                                       : out_sum[SIZE_ADC_DATA-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      step_q        <= '0;
      rise_cnt_q    <= '0;
      out_q         <= OUT_RST;
      pulse_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      step_q        <= step_d;
      rise_cnt_q    <= rise_cnt_d;
      out_q         <= out_d;
      pulse_start_q <= accept;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign output_data = out_q;
  assign pulse_start = pulse_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_v14_pulse_gen.sv
// Directed self-checking bench for v14_pulse_gen: step-rise and 4-cycle-rise instances.
module tb_v14_pulse_gen;

  logic        clk;
  logic        reset;

  logic        trig_valid;
  logic [11:0] trig_amp;
  logic        trig_ready;
  logic [15:0] auto_period;
  logic [11:0] output_data;
  logic        pulse_start;
  logic        busy;

  logic        trig_valid_r;
  logic [11:0] trig_amp_r;
  logic        trig_ready_r;
  logic [15:0] auto_period_r;
  logic [11:0] output_data_r;
  logic        pulse_start_r;
  logic        busy_r;

  int n_checks;
  int n_fail;
  int ps_cnt;

  v14_pulse_gen #(
    .SIZE_ADC_DATA (12),
    .BASELINE      (100),
    .RISE_SHIFT    (0),
    .DECAY_SHIFT   (4),
    .FRAC          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trig_valid  (trig_valid),
    .trig_amp    (trig_amp),
    .trig_ready  (trig_ready),
    .auto_period (auto_period),
    .output_data (output_data),
    .pulse_start (pulse_start),
    .busy        (busy)
  );

  v14_pulse_gen #(
    .SIZE_ADC_DATA (12),
    .BASELINE      (100),
    .RISE_SHIFT    (2),
    .DECAY_SHIFT   (4),
    .FRAC          (4)
  ) dut_r (
    .clk         (clk),
    .reset       (reset),
    .trig_valid  (trig_valid_r),
    .trig_amp    (trig_amp_r),
    .trig_ready  (trig_ready_r),
    .auto_period (auto_period_r),
    .output_data (output_data_r),
    .pulse_start (pulse_start_r),
    .busy        (busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pulse_start) ps_cnt++;
  endtask

  // sel 0 watches the step instance, sel 1 the slow-rise instance.
  task automatic wait_idle(input string tag, input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? busy : busy_r) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, (sel == 0) ? int'(busy) : int'(busy_r), 0);
  endtask

  int outs [10];
  int rdy_low;
  int first_nb;
  int pos [3];
  int k;
  int gap;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ps_cnt   = 0;
    reset = 1'b1;
    trig_valid = 1'b0;   trig_amp = '0;   auto_period = '0;
    trig_valid_r = 1'b0; trig_amp_r = '0; auto_period_r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", output_data, 100);
    chk("rst_busy", busy, 0);
    chk("rst_pstart", pulse_start, 0);
    chk("rst_ready", trig_ready, 1);
    chk("rst_out_r", output_data_r, 100);
    reset = 1'b0;
    tick();

    // single pulse, amp 1600
    ps_cnt = 0;
    trig_amp = 12'd1600; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    chk("sp_pstart", pulse_start, 1);
    chk("sp_busy", busy, 1);
    chk("sp_out_e0", output_data, 100);
    tick(); chk("sp_out_e1", output_data, 1700);
    chk("sp_pstart_once", pulse_start, 0);
    tick(); chk("sp_out_e2", output_data, 1600);
    tick(); chk("sp_out_e3", output_data, 1506);
    wait_idle("sp_idle", 0);
    tick(); chk("sp_out_base", output_data, 100);
    chk("sp_count", ps_cnt, 1);

    // pile-up: retrigger three edges after the first acceptance
    ps_cnt = 0;
    trig_amp = 12'd1600; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    tick(); tick();
    chk("pu_out_e2", output_data, 1600);
    trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    chk("pu_pstart", pulse_start, 1);
    chk("pu_out_e3", output_data, 1506);
    tick(); chk("pu_out_e4", output_data, 3018);
    wait_idle("pu_idle", 0);
    chk("pu_count", ps_cnt, 2);

    // saturation: two back-to-back full-scale triggers drive acc to its clamp
    trig_amp = 12'd4095; trig_valid = 1'b1;
    tick(); tick();
    trig_valid = 1'b0;
    chk("sat_out_e1", output_data, 4095);
    tick(); chk("sat_out_e2", output_data, 4095);
    tick(); chk("sat_out_e3", output_data, 3940);
    tick(); chk("sat_out_e4", output_data, 3700);
    wait_idle("sat_idle", 0);

    // asynchronous reset in the middle of a pulse
    trig_amp = 12'd1600; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rs_out", output_data, 100);
    chk("rs_busy", busy, 0);
    chk("rs_pstart", pulse_start, 0);
    chk("rs_ready", trig_ready, 1);
    tick();
    reset = 1'b0;
    ps_cnt = 0;
    repeat (10) tick();
    chk("rs_nopulse", ps_cnt, 0);
    chk("rs_out_after", output_data, 100);

    // auto mode, external trigger coincident with the third fire
    trig_amp = 12'd200; auto_period = 16'd50;
    pos[0] = -1; pos[1] = -1; pos[2] = -1;
    k = 0;
    for (int n = 0; n < 160; n++) begin
      tick();
      if (pulse_start) begin
        if (k < 3) pos[k] = n;
        k++;
      end
      if (n == 148) trig_valid = 1'b1;
      if (n == 149) trig_valid = 1'b0;
    end
    chk("au_count", k, 3);
    chk("au_pos0", pos[0], 49);
    chk("au_pos1", pos[1], 99);
    chk("au_pos2", pos[2], 149);
    auto_period = 16'd0;
    ps_cnt = 0;
    wait_idle("au_idle", 0);
    repeat (60) tick();
    chk("au_off_count", ps_cnt, 0);
    chk("au_off_out", output_data, 100);

    // four-cycle rise on the second instance
    trig_amp_r = 12'd400; trig_valid_r = 1'b1;
    tick();
    trig_valid_r = 1'b0;
    chk("rr_pstart", pulse_start_r, 1);
    rdy_low = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      outs[i] = int'(output_data_r);
      if (!trig_ready_r) rdy_low++;
    end
    chk("rr_ready_low", rdy_low, 4);
    first_nb = -1;
    for (int i = 0; i < 10; i++) begin
      if (first_nb < 0 && outs[i] != 100) first_nb = i;
    end
    if (first_nb < 0 || first_nb > 4) begin
      chk("rr_first_nb", first_nb, 2);
    end else begin
      chk("rr_ramp0", outs[first_nb],     200);
      chk("rr_ramp1", outs[first_nb + 1], 300);
      chk("rr_ramp2", outs[first_nb + 2], 400);
      chk("rr_ramp3", outs[first_nb + 3], 500);
      chk("rr_decay", outs[first_nb + 4], 475);
    end
    wait_idle("rr_idle", 1);

    // a request held during RISE is accepted only once ready returns
    trig_amp_r = 12'd400; trig_valid_r = 1'b1;
    tick();
    chk("ho_pstart", pulse_start_r, 1);
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pulse_start_r && gap == 0) begin
        gap = i;
        trig_valid_r = 1'b0;
      end
    end
    trig_valid_r = 1'b0;
    chk("ho_gap", gap, 5);
    wait_idle("ho_idle", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
